// File: rtl/control_sequencer_if.sv
// Control/readback bundle between the sequencer and the ALU-system datapath.
// The master side (sequencer) drives every datapath control and reads back
// the instruction register and ALU flags.
interface control_sequencer_if;
  logic [15:0] ir_out;         // instruction register contents
  logic [3:0]  flags_out;      // {Z,C,N,O}
  logic [2:0]  rf_out_a_sel;
  logic [2:0]  rf_out_b_sel;
  logic [2:0]  rf_fun_sel;
  logic [3:0]  rf_reg_sel;     // {R1,R2,R3,R4}, 1 = enabled
  logic [3:0]  rf_scr_sel;
  logic [4:0]  alu_fun_sel;
  logic        alu_wf;
  logic [1:0]  arf_out_c_sel;
  logic [1:0]  arf_out_d_sel;  // 00/01 = PC, 10 = AR, 11 = SP
  logic [2:0]  arf_fun_sel;
  logic [2:0]  arf_reg_sel;    // {PC,AR,SP}, 1 = enabled
  logic        ir_lh;          // 0 = low byte, 1 = high byte
  logic        ir_write;
  logic        mem_wr;         // 1 = write
  logic        mem_cs;         // active-low chip select
  logic [1:0]  mux_a_sel;
  logic [1:0]  mux_b_sel;
  logic        mux_c_sel;

  modport master (
    input  ir_out, flags_out,
    output rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
           alu_fun_sel, alu_wf, arf_out_c_sel, arf_out_d_sel, arf_fun_sel,
           arf_reg_sel, ir_lh, ir_write, mem_wr, mem_cs, mux_a_sel,
           mux_b_sel, mux_c_sel
  );

  modport slave (
    output ir_out, flags_out,
    input  rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
           alu_fun_sel, alu_wf, arf_out_c_sel, arf_out_d_sel, arf_fun_sel,
           arf_reg_sel, ir_lh, ir_write, mem_wr, mem_cs, mux_a_sel,
           mux_b_sel, mux_c_sel
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the ALU-system datapath.
// Fetches a 16-bit instruction as two bytes (T0 low, T1 high), then executes
// in T2 (and T3 for the two-byte store). Outputs are a combinational decode
// of the current step, IROut and FlagsOut.
module control_sequencer (
  input  logic                       i_clk,
  input  logic                       i_rst,
  control_sequencer_if.master        io_dp,
  output logic                       o_halted,
  output logic [2:0]                 o_seq_t
);

  localparam logic [2:0] FUN_CLR  = 3'b011;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LD   = 3'b010;
  localparam logic [4:0] ALU_ADD  = 5'b10100;
  localparam logic [4:0] ALU_PASA = 5'b10000;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_LDI = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h03;
  localparam logic [5:0] OP_LD  = 6'h04;
  localparam logic [5:0] OP_ST  = 6'h05;
  localparam logic [5:0] OP_HLT = 6'h3F;

  // State encoding doubles as the SeqT step code.
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  state_t     r_state;
  state_t     w_next;
  ctrl_t      w_ctrl;
  logic       w_halted;
  logic [2:0] w_seq_t;

  // Instruction fields
  logic [5:0] w_op;
  logic [1:0] w_rsel;
  logic [2:0] w_rd;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic       w_zero;
  logic       w_unused_flags;

  assign w_op           = io_dp.ir_out[15:10];
  assign w_rsel         = io_dp.ir_out[9:8];
  assign w_rd           = io_dp.ir_out[8:6];
  assign w_rs1          = io_dp.ir_out[5:3];
  assign w_rs2          = io_dp.ir_out[2:0];
  assign w_zero         = io_dp.flags_out[3];
  assign w_unused_flags = ^io_dp.flags_out[2:0];

  // R1 is the MSB of RegSel, so rsel 00 selects 4'b1000.
  function automatic logic [3:0] rsel_onehot(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

  // Rd values 1-4 address R1-R4; anything else suppresses the write.
  function automatic logic [3:0] rd_onehot(input logic [2:0] rd);
    case (rd)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // State register; synchronous reset returns to INIT from any step.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (i_rst) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned (which would infer a latch).
    w_ctrl        = '0;
    w_ctrl.mem_cs = 1'b1;
    w_next        = r_state;
    w_halted      = 1'b0;
    w_seq_t       = r_state;

    if (i_rst) begin
      w_next  = S_INIT;
      w_seq_t = 3'd0;
    end else begin
      case (r_state)
        S_INIT: begin
          w_ctrl.arf_reg_sel = 3'b111;
          w_ctrl.arf_fun_sel = FUN_CLR;
          w_ctrl.rf_reg_sel  = 4'b1111;
          w_ctrl.rf_fun_sel  = FUN_CLR;
          w_next             = S_T0;
        end
        S_T0, S_T1: begin
          // Fetch one byte from M[PC] and post-increment PC.
          w_ctrl.arf_out_d_sel = 2'b00;
          w_ctrl.mem_cs        = 1'b0;
          w_ctrl.mem_wr        = 1'b0;
          w_ctrl.ir_write      = 1'b1;
          w_ctrl.ir_lh         = (r_state == S_T1);
          w_ctrl.arf_reg_sel   = 3'b100;
          w_ctrl.arf_fun_sel   = FUN_INC;
          w_next               = (r_state == S_T0) ? S_T1 : S_T2;
        end
        S_T2: begin
          w_next = S_T0;
          case (w_op)
            OP_BRA, OP_BNE: begin
              if (w_op == OP_BRA || !w_zero) begin
                w_ctrl.mux_b_sel   = 2'b11;
                w_ctrl.arf_reg_sel = 3'b100;
                w_ctrl.arf_fun_sel = FUN_LD;
              end
            end
            OP_LDI: begin
              w_ctrl.mux_a_sel  = 2'b11;
              w_ctrl.rf_reg_sel = rsel_onehot(w_rsel);
              w_ctrl.rf_fun_sel = FUN_LD;
            end
            OP_ADD: begin
              w_ctrl.rf_out_a_sel = w_rs1 - 3'd1;
              w_ctrl.rf_out_b_sel = w_rs2 - 3'd1;
              w_ctrl.alu_fun_sel  = ALU_ADD;
              w_ctrl.alu_wf       = 1'b1;
              w_ctrl.mux_a_sel    = 2'b00;
              w_ctrl.rf_reg_sel   = rd_onehot(w_rd);
              w_ctrl.rf_fun_sel   = FUN_LD;
            end
            OP_LD: begin
              w_ctrl.arf_out_d_sel = 2'b10;
              w_ctrl.mem_cs        = 1'b0;
              w_ctrl.mem_wr        = 1'b0;
              w_ctrl.mux_a_sel     = 2'b10;
              w_ctrl.rf_reg_sel    = rsel_onehot(w_rsel);
              w_ctrl.rf_fun_sel    = FUN_LD;
            end
            OP_ST:   w_next = S_T3;
            OP_HLT:  w_next = S_HALT;
            default: ;
          endcase
        end
        S_T3:    w_next = S_T0;
        S_HALT:  w_halted = 1'b1;
        default: w_next = S_INIT;
      endcase

      // Store writes the low byte in T2 and the high byte in T3, bumping AR
      // after each so the pair lands little-endian at AR, AR+1.
      if ((r_state == S_T2 && w_op == OP_ST) || r_state == S_T3) begin
        w_ctrl.rf_out_a_sel  = {1'b0, w_rsel};
        w_ctrl.alu_fun_sel   = ALU_PASA;
        w_ctrl.mux_c_sel     = (r_state == S_T3);
        w_ctrl.arf_out_d_sel = 2'b10;
        w_ctrl.mem_cs        = 1'b0;
        w_ctrl.mem_wr        = 1'b1;
        w_ctrl.arf_reg_sel   = 3'b010;
        w_ctrl.arf_fun_sel   = FUN_INC;
      end
    end
  end

  assign io_dp.rf_out_a_sel  = w_ctrl.rf_out_a_sel;
  assign io_dp.rf_out_b_sel  = w_ctrl.rf_out_b_sel;
  assign io_dp.rf_fun_sel    = w_ctrl.rf_fun_sel;
  assign io_dp.rf_reg_sel    = w_ctrl.rf_reg_sel;
  assign io_dp.rf_scr_sel    = w_ctrl.rf_scr_sel;
  assign io_dp.alu_fun_sel   = w_ctrl.alu_fun_sel;
  assign io_dp.alu_wf        = w_ctrl.alu_wf;
  assign io_dp.arf_out_c_sel = w_ctrl.arf_out_c_sel;
  assign io_dp.arf_out_d_sel = w_ctrl.arf_out_d_sel;
  assign io_dp.arf_fun_sel   = w_ctrl.arf_fun_sel;
  assign io_dp.arf_reg_sel   = w_ctrl.arf_reg_sel;
  assign io_dp.ir_lh         = w_ctrl.ir_lh;
  assign io_dp.ir_write      = w_ctrl.ir_write;
  assign io_dp.mem_wr        = w_ctrl.mem_wr;
  assign io_dp.mem_cs        = w_ctrl.mem_cs;
  assign io_dp.mux_a_sel     = w_ctrl.mux_a_sel;
  assign io_dp.mux_b_sel     = w_ctrl.mux_b_sel;
  assign io_dp.mux_c_sel     = w_ctrl.mux_c_sel;
  assign o_halted            = w_halted;
  assign o_seq_t             = w_seq_t;

endmodule
